// File: rtl/hdmi_packet_scheduler_pkg.sv
// Shared types and encodings for the HDMI data-island packet scheduler.
package hdmi_pkg;

  localparam logic [7:0] PKT_NULL  = 8'h00;
  localparam logic [7:0] PKT_ACR   = 8'h01;
  localparam logic [7:0] PKT_AUDIO = 8'h02;
  localparam logic [7:0] PKT_AVI   = 8'h82;
  localparam logic [7:0] PKT_AIF   = 8'h84;

  typedef enum logic [7:0] {
    TYPE_NULL  = PKT_NULL,
    TYPE_ACR   = PKT_ACR,
    TYPE_AUDIO = PKT_AUDIO,
    TYPE_AVI   = PKT_AVI,
    TYPE_AIF   = PKT_AIF
  } packet_type_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

  // Fixed-priority pick among the pending packet sources.
  function automatic packet_type_t pick_packet(logic acr, logic audio, logic avi, logic aif);
    if (acr)   return TYPE_ACR;
    if (audio) return TYPE_AUDIO;
    if (avi)   return TYPE_AVI;
    if (aif)   return TYPE_AIF;
    return TYPE_NULL;
  endfunction

endpackage

// File: rtl/hdmi_packet_scheduler_if.sv
// Slot request / packet select bundle between the timing generator and the scheduler.
interface hdmi_packet_scheduler_if;
  logic       packet_enable;
  logic       frame_start;
  logic       acr_toggle;
  logic [2:0] sample_count;
  logic [7:0] packet_type;
  logic       packet_grant;
  logic [2:0] samples_taken;
  logic       slot_busy;
  logic       acr_overrun;
  logic       infoframe_missed;
  logic       slot_refused;

  modport master (
    output packet_enable, frame_start, acr_toggle, sample_count,
    input  packet_type, packet_grant, samples_taken, slot_busy,
           acr_overrun, infoframe_missed, slot_refused
  );

  modport slave (
    input  packet_enable, frame_start, acr_toggle, sample_count,
    output packet_type, packet_grant, samples_taken, slot_busy,
           acr_overrun, infoframe_missed, slot_refused
  );
endinterface

// File: rtl/hdmi_toggle_edge_detect.sv
// Turns a toggle-style handshake level into a one-cycle change indication.
module hdmi_toggle_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic toggle,
  output logic toggle_edge
);

  logic toggle_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) toggle_q <= 1'b0;
    else        toggle_q <= toggle;
  end

  assign toggle_edge = toggle ^ toggle_q;

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// Per-slot arbiter choosing the next data-island packet type in the pixel clock domain.
module hdmi_packet_scheduler
  import hdmi_pkg::*;
#(
  parameter int PACKET_CYCLES    = 32,
  parameter int MAX_SAMPLES      = 4,
  parameter int INFOFRAME_PERIOD = 1
) (
  input logic                     clk_pixel,
  input logic                     reset_n,
  hdmi_packet_scheduler_if.slave  bus
);

  localparam int              CNT_W    = $clog2(PACKET_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACKET_CYCLES - 1);
  localparam logic [3:0]      FRM_LAST = 4'(INFOFRAME_PERIOD - 1);
  localparam logic [2:0]      MAX_S    = 3'(MAX_SAMPLES);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] busy_cnt;
  logic [3:0]       frame_cnt;
  logic             acr_edge, acr_pend, avi_pend, aif_pend;
  logic             accept, refuse, rearm;
  logic             grant_acr, grant_avi, grant_aif;
  packet_type_t     winner, type_q;
  logic             grant_q, overrun_q, missed_q, refused_q;
  logic [2:0]       taken_q, take_n;

  hdmi_toggle_edge_detect u_acr_edge (
    .clk         (clk_pixel),
    .rst_n       (reset_n),
    .toggle      (bus.acr_toggle),
    .toggle_edge (acr_edge)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    refuse  = 1'b0;
    case (state_q)
      IDLE: if (bus.packet_enable) begin
        accept  = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        refuse = bus.packet_enable;
        if (busy_cnt == CNT_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign winner    = pick_packet(acr_pend, bus.sample_count != 3'd0, avi_pend, aif_pend);
  assign grant_acr = accept && (winner == TYPE_ACR);
  assign grant_avi = accept && (winner == TYPE_AVI);
  assign grant_aif = accept && (winner == TYPE_AIF);
  assign rearm     = bus.frame_start && (frame_cnt == FRM_LAST);
  assign take_n    = (bus.sample_count > MAX_S) ? MAX_S : bus.sample_count;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      busy_cnt <= '0;
    end else begin
      state_q  <= state_d;
      busy_cnt <= (state_q == BUSY && busy_cnt != CNT_LAST) ? busy_cnt + 1'b1 : '0;
    end
  end

  // A request arriving in the same cycle as its own grant re-sets the flag, so it is not lost.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_pend  <= 1'b0;
      avi_pend  <= 1'b0;
      aif_pend  <= 1'b0;
      frame_cnt <= '0;
      overrun_q <= 1'b0;
      missed_q  <= 1'b0;
      refused_q <= 1'b0;
    end else begin
      acr_pend  <= acr_edge | (acr_pend & ~grant_acr);
      avi_pend  <= rearm    | (avi_pend & ~grant_avi);
      aif_pend  <= rearm    | (aif_pend & ~grant_aif);
      overrun_q <= overrun_q | (acr_edge & acr_pend & ~grant_acr);
      missed_q  <= missed_q  | (rearm & ((avi_pend & ~grant_avi) | (aif_pend & ~grant_aif)));
      refused_q <= refused_q | refuse;
      if (bus.frame_start) frame_cnt <= rearm ? 4'd0 : frame_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      type_q  <= TYPE_NULL;
      grant_q <= 1'b0;
      taken_q <= '0;
    end else begin
      grant_q <= accept;
      taken_q <= (accept && winner == TYPE_AUDIO) ? take_n : 3'd0;
      if (accept) type_q <= winner;
    end
  end

  assign bus.packet_type      = type_q;
  assign bus.packet_grant     = grant_q;
  assign bus.samples_taken    = taken_q;
  assign bus.slot_busy        = (state_q == BUSY);
  assign bus.acr_overrun      = overrun_q;
  assign bus.infoframe_missed = missed_q;
  assign bus.slot_refused     = refused_q;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed bench for hdmi_packet_scheduler with a cycle-level reference model.
module tb_hdmi_packet_scheduler;

  localparam int PC   = 32;
  localparam int MAXS = 4;
  localparam int IFP  = 1;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  hdmi_packet_scheduler_if bus();

  hdmi_packet_scheduler #(
    .PACKET_CYCLES    (PC),
    .MAX_SAMPLES      (MAXS),
    .INFOFRAME_PERIOD (IFP)
  ) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct packed {
    logic       acr_prev;
    logic       acr_p;
    logic       avi_p;
    logic       aif_p;
    int         busy_left;
    int         frame;
    logic [7:0] ptype;
    logic       grant;
    logic [2:0] taken;
    logic       ovr;
    logic       miss;
    logic       refused;
  } mdl_t;

  mdl_t mdl;

  // One pixel clock of the scheduling rules, expressed on plain flags and a countdown.
  function automatic mdl_t step(mdl_t m, logic pe, logic fs, logic tog, logic [2:0] sc);
    mdl_t       n    = m;
    logic       busy = (m.busy_left > 0);
    logic       take = pe && !busy;
    logic [7:0] win;
    if (m.acr_p)       win = 8'h01;
    else if (sc >= 1)  win = 8'h02;
    else if (m.avi_p)  win = 8'h82;
    else if (m.aif_p)  win = 8'h84;
    else               win = 8'h00;
    n.grant = take;
    n.taken = 3'd0;
    if (take) begin
      n.ptype     = win;
      n.busy_left = PC;
      if (win == 8'h02) n.taken = (int'(sc) > MAXS) ? 3'(MAXS) : sc;
      if (win == 8'h01) n.acr_p = 1'b0;
      if (win == 8'h82) n.avi_p = 1'b0;
      if (win == 8'h84) n.aif_p = 1'b0;
    end else if (busy) begin
      n.busy_left = m.busy_left - 1;
      if (pe) n.refused = 1'b1;
    end
    if (tog != m.acr_prev) begin
      if (n.acr_p) n.ovr = 1'b1;
      n.acr_p = 1'b1;
    end
    n.acr_prev = tog;
    if (fs) begin
      n.frame = (m.frame + 1) % IFP;
      if (n.frame == 0) begin
        if (n.avi_p || n.aif_p) n.miss = 1'b1;
        n.avi_p = 1'b1;
        n.aif_p = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) mdl <= '0;
    else          mdl <= step(mdl, bus.packet_enable, bus.frame_start, bus.acr_toggle, bus.sample_count);
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%02h expected 0x%02h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk_pixel) begin
    if (reset_n) begin
      check("m_type",    bus.packet_type,             mdl.ptype);
      check("m_grant",   8'(bus.packet_grant),        8'(mdl.grant));
      check("m_taken",   8'(bus.samples_taken),       8'(mdl.taken));
      check("m_busy",    8'(bus.slot_busy),           8'(mdl.busy_left > 0));
      check("m_overrun", 8'(bus.acr_overrun),         8'(mdl.ovr));
      check("m_missed",  8'(bus.infoframe_missed),    8'(mdl.miss));
      check("m_refused", 8'(bus.slot_refused),        8'(mdl.refused));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pixel);
    #1;
  endtask

  task automatic slot(input logic [7:0] exp_type, input logic [2:0] exp_taken);
    bus.packet_enable = 1'b1;
    tick(1);
    bus.packet_enable = 1'b0;
    check("slot_grant", 8'(bus.packet_grant),  8'h01);
    check("slot_type",  bus.packet_type,       exp_type);
    check("slot_taken", 8'(bus.samples_taken), 8'(exp_taken));
    check("slot_busy",  8'(bus.slot_busy),     8'h01);
  endtask

  task automatic refused_slot(input logic [7:0] held_type);
    bus.packet_enable = 1'b1;
    tick(1);
    bus.packet_enable = 1'b0;
    check("ref_grant",   8'(bus.packet_grant), 8'h00);
    check("ref_type",    bus.packet_type,      held_type);
    check("ref_sticky",  8'(bus.slot_refused), 8'h01);
  endtask

  task automatic pulse_frame();
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_type"},    bus.packet_type,              8'h00);
    check({tag, "_grant"},   8'(bus.packet_grant),         8'h00);
    check({tag, "_taken"},   8'(bus.samples_taken),        8'h00);
    check({tag, "_busy"},    8'(bus.slot_busy),            8'h00);
    check({tag, "_overrun"}, 8'(bus.acr_overrun),          8'h00);
    check({tag, "_missed"},  8'(bus.infoframe_missed),     8'h00);
    check({tag, "_refused"}, 8'(bus.slot_refused),         8'h00);
  endtask

  initial begin
    bus.packet_enable = 1'b0;
    bus.frame_start   = 1'b0;
    bus.acr_toggle    = 1'b0;
    bus.sample_count  = 3'd0;
    tick(3);
    check_all_zero("rst");
    reset_n = 1'b1;

    // Null slot with no requests; window spans exactly PC cycles.
    tick(9);
    slot(8'h00, 3'd0);
    tick(31);
    check("busy_last", 8'(bus.slot_busy), 8'h01);
    tick(1);
    check("busy_end",  8'(bus.slot_busy), 8'h00);

    // ACR beats audio; audio take clamps at MAX_SAMPLES.
    bus.acr_toggle   = 1'b1;
    bus.sample_count = 3'd5;
    tick(1);
    slot(8'h01, 3'd0);
    tick(39);
    slot(8'h02, 3'd4);
    tick(1);
    check("taken_clr", 8'(bus.samples_taken), 8'h00);
    bus.sample_count = 3'd0;
    tick(38);

    // frame_start together with a slot: arbitration sees pre-frame state.
    bus.frame_start   = 1'b1;
    bus.packet_enable = 1'b1;
    tick(1);
    bus.frame_start   = 1'b0;
    bus.packet_enable = 1'b0;
    check("fs_pe_type", bus.packet_type, 8'h00);
    tick(39);
    slot(8'h82, 3'd0);
    tick(39);
    slot(8'h84, 3'd0);
    tick(39);
    slot(8'h00, 3'd0);
    check("no_missed", 8'(bus.infoframe_missed), 8'h00);
    tick(39);

    // ACR edge coinciding with its own grant stays pending without overrun.
    bus.acr_toggle = 1'b0;
    tick(1);
    bus.acr_toggle = 1'b1;
    slot(8'h01, 3'd0);
    check("setwin_ovr", 8'(bus.acr_overrun), 8'h00);
    tick(39);
    slot(8'h01, 3'd0);

    // Refusals: early in the window and in the final busy cycle.
    tick(39);
    bus.sample_count = 3'd2;
    slot(8'h02, 3'd2);
    bus.sample_count = 3'd0;
    tick(4);
    refused_slot(8'h02);
    tick(26);
    refused_slot(8'h02);
    slot(8'h00, 3'd0);
    tick(39);

    // Two ACR edges with no slot between them.
    bus.acr_toggle = 1'b0;
    tick(1);
    bus.acr_toggle = 1'b1;
    tick(1);
    check("overrun", 8'(bus.acr_overrun), 8'h01);
    slot(8'h01, 3'd0);
    tick(39);
    slot(8'h00, 3'd0);
    tick(39);

    // Two re-arms with no slot between them.
    pulse_frame();
    pulse_frame();
    check("missed", 8'(bus.infoframe_missed), 8'h01);

    // Asynchronous reset in the middle of a window.
    slot(8'h82, 3'd0);
    tick(5);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("arst");
    tick(2);
    reset_n = 1'b1;
    tick(1);
    slot(8'h01, 3'd0);
    tick(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
